// File: rtl/mem_responder.sv
// Memory-side responder for the mini CPU: a word-addressed RAM with programmable
// wait states that answers Read/Write strobes with a registered one-cycle Ready pulse.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [DATA_W-1:0] MDR_wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Ready,
  output logic              Error,
  output logic              Busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_t;

  state_t state, next_state;

  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_write;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              one_req;
  logic              conflict;
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] rd_word;

  assign one_req  = Read ^ Write;
  assign conflict = Read & Write;
  assign in_range = ({1'b0, lat_addr} < DEPTH_W);
  assign mem_idx  = lat_addr[IDX_W-1:0];
  assign rd_word  = in_range ? mem[mem_idx] : '0;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (one_req)       next_state = (WS == 4'd0) ? ST_ACCESS : ST_WAIT;
        else if (conflict) next_state = ST_DONE;
      end
      ST_WAIT:   if (wait_cnt == 4'd1) next_state = ST_ACCESS;
      ST_ACCESS: next_state = ST_DONE;
      // Held requests park here so a level strobe never triggers a second access.
      ST_DONE:   if (!Read && !Write) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != ST_IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      Mdatain   <= '0;
      Ready     <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Ready <= 1'b0;
      Error <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (one_req) begin
            lat_addr  <= MAR_addr;
            lat_data  <= MDR_wdata;
            lat_write <= Write;
            wait_cnt  <= WS;
          end else if (conflict) begin
            Ready <= 1'b1;
            Error <= 1'b1;
          end
        end
        ST_WAIT: wait_cnt <= wait_cnt - 4'd1;
        ST_ACCESS: begin
          Ready <= 1'b1;
          Error <= !in_range;
          if (!lat_write) Mdatain <= rd_word;
        end
        default: ;
      endcase
    end
  end

  // The array is deliberately unreset so its contents survive Reset.
  always_ff @(posedge Clock) begin
    if (state == ST_ACCESS && lat_write && in_range) mem[mem_idx] <= lat_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a behavioural RAM model
// that predicts latency, Ready/Error flags and returned read data.
module tb_mem_responder;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 256;
  localparam int DATA_W = 32;
  localparam int WS     = 2;

  logic              Clock;
  logic              Reset;
  logic              Read;
  logic              Write;
  logic [ADDR_W-1:0] MAR_addr;
  logic [DATA_W-1:0] MDR_wdata;
  logic [DATA_W-1:0] Mdatain;
  logic              Ready;
  logic              Error;
  logic              Busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_mdata;
  logic [8:0]  pool [16];

  mem_responder #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .WAIT_STATES(WS)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write),
    .MAR_addr(MAR_addr), .MDR_wdata(MDR_wdata),
    .Mdatain(Mdatain), .Ready(Ready), .Error(Error), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge Clock);
    #1;
  endtask

  // One complete single-request access: accept, wait states, Ready pulse, optional hold, release.
  task automatic applyStimulus(input bit is_write, input logic [8:0] addr,
                               input logic [31:0] data, input int hold_extra);
    bit in_rng;
    in_rng    = (addr < 9'(DEPTH));
    Read      = !is_write;
    Write     = is_write;
    MAR_addr  = addr;
    MDR_wdata = data;
    stepCycle();
    MAR_addr  = 9'($urandom);
    MDR_wdata = $urandom;
    checkOutput("busy_after_accept", Busy, 1);
    checkOutput("ready_at_accept", Ready, 0);
    for (int k = 1; k <= WS; k++) begin
      stepCycle();
      checkOutput("ready_early", Ready, 0);
    end
    stepCycle();
    if (is_write && in_rng) ref_mem[addr[7:0]] = data;
    if (!is_write) exp_mdata = in_rng ? ref_mem[addr[7:0]] : 32'h0;
    checkOutput("ready_pulse", Ready, 1);
    checkOutput("error_flag", Error, {31'b0, !in_rng});
    checkOutput("mdatain", Mdatain, exp_mdata);
    for (int k = 0; k < hold_extra; k++) begin
      stepCycle();
      checkOutput("ready_held", Ready, 0);
      checkOutput("busy_held", Busy, 1);
    end
    Read  = 1'b0;
    Write = 1'b0;
    stepCycle();
    checkOutput("ready_cleared", Ready, 0);
    checkOutput("busy_released", Busy, 0);
  endtask

  task automatic conflictAccess(input logic [8:0] addr);
    Read      = 1'b1;
    Write     = 1'b1;
    MAR_addr  = addr;
    MDR_wdata = $urandom;
    stepCycle();
    checkOutput("conflict_ready", Ready, 1);
    checkOutput("conflict_error", Error, 1);
    checkOutput("conflict_mdatain", Mdatain, exp_mdata);
    stepCycle();
    checkOutput("conflict_ready_once", Ready, 0);
    checkOutput("conflict_busy_held", Busy, 1);
    Read  = 1'b0;
    Write = 1'b0;
    stepCycle();
    checkOutput("conflict_busy_released", Busy, 0);
  endtask

  initial begin
    int sel;
    int hold;
    logic [8:0] a_in;
    logic [8:0] a_oob;

    Reset = 1'b0; Read = 1'b0; Write = 1'b0; MAR_addr = '0; MDR_wdata = '0;
    exp_mdata = 32'h0;
    pool[0] = 9'h012; pool[1] = 9'h005; pool[2] = 9'h0F0; pool[3] = 9'h000; pool[4] = 9'h0FF;
    for (int i = 5; i < 16; i++) pool[i] = 9'($urandom_range(0, DEPTH - 1));

    stepCycle();
    stepCycle();
    checkOutput("reset_mdatain", Mdatain, 0);
    checkOutput("reset_ready", Ready, 0);
    checkOutput("reset_error", Error, 0);
    checkOutput("reset_busy", Busy, 0);
    Reset = 1'b1;
    stepCycle();
    checkOutput("post_reset_busy", Busy, 0);

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, pool[i], $urandom, 0);

    applyStimulus(1'b1, 9'h012, 32'hDEADBEEF, 0);
    applyStimulus(1'b0, 9'h012, 32'h0, 0);
    applyStimulus(1'b1, 9'h005, 32'hAAAAAAAA, 0);

    $display("[TB] held read request");
    applyStimulus(1'b0, 9'h012, 32'h0, 7);

    $display("[TB] conflicting request");
    conflictAccess(9'h012);
    applyStimulus(1'b0, 9'h012, 32'h0, 0);

    $display("[TB] out-of-range accesses");
    applyStimulus(1'b0, 9'h1F0, 32'h0, 0);
    applyStimulus(1'b1, 9'h1F0, 32'h55AA55AA, 0);
    applyStimulus(1'b0, 9'h0F0, 32'h0, 0);

    $display("[TB] reset abort during wait states");
    applyStimulus(1'b0, 9'h005, 32'h0, 0);
    Write = 1'b1; MAR_addr = 9'h005; MDR_wdata = 32'h12345678;
    stepCycle();
    stepCycle();
    #3 Reset = 1'b0;
    #1;
    exp_mdata = 32'h0;
    checkOutput("abort_busy", Busy, 0);
    checkOutput("abort_ready", Ready, 0);
    checkOutput("abort_error", Error, 0);
    checkOutput("abort_mdatain", Mdatain, exp_mdata);
    Write = 1'b0;
    stepCycle();
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      checkOutput("abort_no_ready", Ready, 0);
    end
    applyStimulus(1'b0, 9'h005, 32'h0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      sel   = $urandom_range(0, 9);
      hold  = $urandom_range(0, 3);
      a_in  = pool[$urandom_range(0, 15)];
      a_oob = 9'($urandom_range(DEPTH, 511));
      case (sel)
        0, 1, 2: applyStimulus(1'b0, a_in, 32'h0, hold);
        3, 4, 5: applyStimulus(1'b1, a_in, $urandom, hold);
        6:       applyStimulus(1'b0, a_oob, 32'h0, hold);
        7:       applyStimulus(1'b1, a_oob, $urandom, hold);
        8:       conflictAccess(a_in);
        default: applyStimulus(1'b0, a_in, 32'h0, 9);
      endcase
    end

    for (int i = 0; i < 16; i++) applyStimulus(1'b0, pool[i], 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
